// File: rtl/voice_allocator.sv
// voice_allocator
// ---------------
// Dynamic voice allocator placed between a note-event source and NCH
// note_synthesizer channels. Note-on events go to a matching channel
// (retrigger), else to the lowest free channel, else steal the
// least-recently-allocated channel. On a steal the victim is silenced
// for one cycle (GAP) before the new note is loaded. Note-off events
// clear the matching channel.
//
// Ports
//   baseclk     system clock, all state changes on the rising edge
//   asyncrst_n  active-low reset, sampled on the rising edge only
//   all_off     synchronous panic: clears every channel, drops held event
//   ev_valid    event offered
//   ev_ready    allocator can accept an event (IDLE and not all_off)
//   ev_on       1 = note-on, 0 = note-off
//   ev_octave   event octave
//   ev_note     event note
//   ev_duty     event duty (note-on only)
//   ev_mode     event mode (note-on only; 2'b00 behaves as note-off)
//   octave      packed per-channel octave (channel k in slice k)
//   note        packed per-channel note
//   duty        packed per-channel duty
//   mode        packed per-channel mode, 2'b00 = silent
//   busy        channel k holds an active note
//   steal       one-cycle pulse when a busy channel is reassigned
module voice_allocator #(
    parameter int NCH = 4,
    parameter int RW  = 2
) (
    input  logic             baseclk,
    input  logic             asyncrst_n,
    input  logic             all_off,
    input  logic             ev_valid,
    output logic             ev_ready,
    input  logic             ev_on,
    input  logic [2:0]       ev_octave,
    input  logic [3:0]       ev_note,
    input  logic [3:0]       ev_duty,
    input  logic [1:0]       ev_mode,
    output logic [3*NCH-1:0] octave,
    output logic [4*NCH-1:0] note,
    output logic [4*NCH-1:0] duty,
    output logic [2*NCH-1:0] mode,
    output logic [NCH-1:0]   busy,
    output logic             steal
);

    localparam int            IW          = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [RW-1:0] RANK_OLDEST = RW'(NCH - 1);

    // LOOKUP registers the search decision; APPLY executes it. This keeps
    // the channel-table compare off the path into the channel registers.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_APPLY  = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_CLEAR = 2'd1,
        ACT_LOAD  = 2'd2,
        ACT_STEAL = 2'd3
    } act_t;

    // Lowest set bit index of a channel vector (0 when empty).
    function automatic logic [IW-1:0] lowest_set(input logic [NCH-1:0] vec);
        logic [IW-1:0] idx;
        idx = {IW{1'b0}};
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = vec[k] ? IW'(k) : idx;
        end
        return idx;
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    act_t            act_r;
    act_t            act_nxt_s;
    logic [IW-1:0]   tgt_r;
    logic [IW-1:0]   tgt_nxt_s;

    logic            ev_on_r;
    logic [2:0]      ev_octave_r;
    logic [3:0]      ev_note_r;
    logic [3:0]      ev_duty_r;
    logic [1:0]      ev_mode_r;

    logic [2:0]      ch_octave_r [NCH];
    logic [3:0]      ch_note_r   [NCH];
    logic [3:0]      ch_duty_r   [NCH];
    logic [1:0]      ch_mode_r   [NCH];
    logic [NCH-1:0]  busy_r;
    logic            steal_r;
    logic [RW-1:0]   rank_r      [NCH];

    logic [NCH-1:0]  match_vec_s;
    logic [NCH-1:0]  free_vec_s;
    logic [NCH-1:0]  victim_vec_s;
    logic            xfer_s;
    logic            touch_s;

    assign ev_ready = (state_r == ST_IDLE) & ~all_off;
    assign xfer_s   = ev_valid & ev_ready;
    // The loaded channel becomes newest on a plain load/retrigger or at the end of a steal.
    assign touch_s  = ((state_r == ST_APPLY) && (act_r == ACT_LOAD)) || (state_r == ST_GAP);

    // Next-state logic; all_off always returns to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        if (all_off) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        state_nxt_s = ST_LOOKUP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_LOOKUP: state_nxt_s = ST_APPLY;
                ST_APPLY: begin
                    if (act_r == ACT_STEAL) begin
                        state_nxt_s = ST_GAP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_GAP:  state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Per-channel match / free / oldest flags against the held event.
    always_comb begin
        match_vec_s  = {NCH{1'b0}};
        free_vec_s   = {NCH{1'b0}};
        victim_vec_s = {NCH{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            match_vec_s[k]  = busy_r[k] & (ch_octave_r[k] == ev_octave_r)
                                        & (ch_note_r[k] == ev_note_r);
            free_vec_s[k]   = ~busy_r[k];
            victim_vec_s[k] = (rank_r[k] == RANK_OLDEST);
        end
    end

    // Action decision for the held event.
    always_comb begin
        act_nxt_s = ACT_NONE;
        tgt_nxt_s = {IW{1'b0}};
        if (!ev_on_r) begin
            if (|match_vec_s) begin
                act_nxt_s = ACT_CLEAR;
                tgt_nxt_s = lowest_set(match_vec_s);
            end else begin
                act_nxt_s = ACT_NONE;
            end
        end else if (|match_vec_s) begin
            act_nxt_s = ACT_LOAD;
            tgt_nxt_s = lowest_set(match_vec_s);
        end else if (|free_vec_s) begin
            act_nxt_s = ACT_LOAD;
            tgt_nxt_s = lowest_set(free_vec_s);
        end else begin
            act_nxt_s = ACT_STEAL;
            tgt_nxt_s = lowest_set(victim_vec_s);
        end
    end

    // FSM state, held event and registered decision.
    always_ff @(posedge baseclk) begin
        if (!asyncrst_n) begin
            state_r     <= ST_IDLE;
            ev_on_r     <= 1'b0;
            ev_octave_r <= 3'd0;
            ev_note_r   <= 4'd0;
            ev_duty_r   <= 4'd0;
            ev_mode_r   <= 2'd0;
            act_r       <= ACT_NONE;
            tgt_r       <= {IW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (xfer_s) begin
                // A note-on with mode 00 is folded into a note-off here.
                ev_on_r     <= ev_on & (ev_mode != 2'b00);
                ev_octave_r <= ev_octave;
                ev_note_r   <= ev_note;
                ev_duty_r   <= ev_duty;
                ev_mode_r   <= ev_mode;
            end
            if (state_r == ST_LOOKUP) begin
                act_r <= act_nxt_s;
                tgt_r <= tgt_nxt_s;
            end
        end
    end

    // Channel table, busy flags and steal pulse.
    always_ff @(posedge baseclk) begin
        if (!asyncrst_n || all_off) begin
            for (int k = 0; k < NCH; k++) begin
                ch_octave_r[k] <= 3'd0;
                ch_note_r[k]   <= 4'd0;
                ch_duty_r[k]   <= 4'd0;
                ch_mode_r[k]   <= 2'd0;
            end
            busy_r  <= {NCH{1'b0}};
            steal_r <= 1'b0;
        end else begin
            steal_r <= 1'b0;
            if (state_r == ST_APPLY) begin
                case (act_r)
                    ACT_CLEAR: begin
                        ch_octave_r[tgt_r] <= 3'd0;
                        ch_note_r[tgt_r]   <= 4'd0;
                        ch_duty_r[tgt_r]   <= 4'd0;
                        ch_mode_r[tgt_r]   <= 2'd0;
                        busy_r[tgt_r]      <= 1'b0;
                    end
                    ACT_LOAD: begin
                        ch_octave_r[tgt_r] <= ev_octave_r;
                        ch_note_r[tgt_r]   <= ev_note_r;
                        ch_duty_r[tgt_r]   <= ev_duty_r;
                        ch_mode_r[tgt_r]   <= ev_mode_r;
                        busy_r[tgt_r]      <= 1'b1;
                    end
                    ACT_STEAL: begin
                        // Silence the victim for one cycle before reloading it.
                        ch_mode_r[tgt_r] <= 2'd0;
                        steal_r          <= 1'b1;
                    end
                    default: begin
                        steal_r <= 1'b0;
                    end
                endcase
            end else if (state_r == ST_GAP) begin
                ch_octave_r[tgt_r] <= ev_octave_r;
                ch_note_r[tgt_r]   <= ev_note_r;
                ch_duty_r[tgt_r]   <= ev_duty_r;
                ch_mode_r[tgt_r]   <= ev_mode_r;
                busy_r[tgt_r]      <= 1'b1;
            end
        end
    end

    // LRU ranks: 0 = newest, NCH-1 = oldest; kept across all_off.
    always_ff @(posedge baseclk) begin
        if (!asyncrst_n) begin
            for (int k = 0; k < NCH; k++) begin
                rank_r[k] <= RW'(k);
            end
        end else if (touch_s && !all_off) begin
            for (int i = 0; i < NCH; i++) begin
                if (IW'(i) == tgt_r) begin
                    rank_r[i] <= {RW{1'b0}};
                end else if (rank_r[i] < rank_r[tgt_r]) begin
                    rank_r[i] <= rank_r[i] + RW'(1);
                end
            end
        end
    end

    // Pack the channel table into the synthesizer bus layout.
    for (genvar k = 0; k < NCH; k++) begin : g_pack
        assign octave[3*k +: 3] = ch_octave_r[k];
        assign note[4*k +: 4]   = ch_note_r[k];
        assign duty[4*k +: 4]   = ch_duty_r[k];
        assign mode[2*k +: 2]   = ch_mode_r[k];
    end

    assign busy  = busy_r;
    assign steal = steal_r;

endmodule
